trace_cmd_sequencer: RTL and testbench

Upstream feeder for the `processor` cache-lookup stage. It accepts raw trace commands (opcode and 32-bit address) over a valid/ready handshake and buffers them in a FIFO. It decodes each address into tag/set/offset and presents one `command_t` at a time to `processor`, holding it stable long enough for that stage's previous/current instruction registers to settle. Opcodes 8 (clear) and 9 (print) become one-cycle sideband pulses, illegal opcodes are dropped, and per-type statistics are kept.

---
 rtl/trace_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_trace_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_sequencer.sv
// rtl/trace_cmd_sequencer.sv - trace command FIFO, decoder and issue sequencer for the cache-lookup stage
//
// Buffers raw trace commands, decodes each address into tag/set/offset and
// presents one command at a time to the downstream lookup stage.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    trace command handshake (in_ready = FIFO not full)
//   in_n, in_addr        trace opcode and byte address
//   instruction_o        decoded command {n[3:0], tag[11:0], set_index[13:0], byte_offset[5:0]}
//   out_valid/out_ready  downstream handshake for instruction_o
//   clear_o, print_o     one-cycle pulses for opcodes 8 and 9
//   busy                 FIFO non-empty or sequencer not idle
//   *_cnt                saturating per-type statistics

module trace_cmd_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_n,
    input  logic [31:0]      in_addr,
    output logic [35:0]      instruction_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             clear_o,
    output logic             print_o,
    output logic             busy,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] if_cnt,
    output logic [CNT_W-1:0] other_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        SPECIAL
    } state_t;

    state_t            state;
    logic [HC_W-1:0]   hold_cnt;

    // FIFO storage: each entry is {opcode, address}
    logic [35:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              push;
    logic              pop;
    logic [3:0]        head_n;
    logic [31:0]       head_addr;

    assign in_ready  = (count != (PTR_W + 1)'(DEPTH));
    assign push      = in_valid && in_ready;
    // Every entry is consumed from IDLE, including specials and illegal opcodes,
    // so FIFO order is preserved across all command kinds.
    assign pop       = (state == IDLE) && (count != '0);
    assign head_n    = mem[rd_ptr][35:32];
    assign head_addr = mem[rd_ptr][31:0];
    assign busy      = (count != '0) || (state != IDLE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_n, in_addr};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            instruction_o <= '0;
            out_valid     <= 1'b0;
            clear_o       <= 1'b0;
            print_o       <= 1'b0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            if_cnt        <= '0;
            other_cnt     <= '0;
            bad_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (head_n <= 4'd4) begin
                            instruction_o <= {head_n, head_addr[31:20], head_addr[19:6], head_addr[5:0]};
                            out_valid     <= 1'b1;
                            state         <= ISSUE;
                        end else if (head_n == 4'd8 || head_n == 4'd9) begin
                            clear_o <= (head_n == 4'd8);
                            print_o <= (head_n == 4'd9);
                            state   <= SPECIAL;
                        end else begin
                            // Illegal opcode: consumed and counted, instruction_o untouched.
                            bad_cnt <= sat_inc(bad_cnt);
                        end
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        case (instruction_o[35:32])
                            4'd0:    rd_cnt    <= sat_inc(rd_cnt);
                            4'd1:    wr_cnt    <= sat_inc(wr_cnt);
                            4'd2:    if_cnt    <= sat_inc(if_cnt);
                            default: other_cnt <= sat_inc(other_cnt);
                        endcase
                        if (HOLD_CYCLES == 1) begin
                            state <= IDLE;
                        end else begin
                            hold_cnt <= HC_W'(HOLD_CYCLES - 1);
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // instruction_o stays put so the downstream stage's
                    // previous/current registers see a stable value.
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt <= HC_W'(1)) begin
                        state <= IDLE;
                    end
                end
                SPECIAL: begin
                    clear_o <= 1'b0;
                    print_o <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// tb/tb_trace_cmd_sequencer.sv - scoreboard bench for trace_cmd_sequencer

module tb_trace_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int HOLD  = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_n;
    logic [31:0]      in_addr;
    logic [35:0]      instruction_o;
    logic             out_valid;
    logic             out_ready;
    logic             clear_o;
    logic             print_o;
    logic             busy;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] if_cnt;
    logic [CNT_W-1:0] other_cnt;
    logic [CNT_W-1:0] bad_cnt;

    trace_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_n          (in_n),
        .in_addr       (in_addr),
        .instruction_o (instruction_o),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clear_o       (clear_o),
        .print_o       (print_o),
        .busy          (busy),
        .rd_cnt        (rd_cnt),
        .wr_cnt        (wr_cnt),
        .if_cnt        (if_cnt),
        .other_cnt     (other_cnt),
        .bad_cnt       (bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard events: {kind, instr}; kind 0 = command, 1 = clear, 2 = print
    logic [37:0] sb[$];
    int          stamps[$];
    int          exp_rd, exp_wr, exp_if, exp_oth, exp_bad;

    function automatic logic [35:0] decode(input logic [3:0] n, input logic [31:0] a);
        return {n, a[31:20], a[19:6], a[5:0]};
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        sb.delete();
        exp_rd = 0; exp_wr = 0; exp_if = 0; exp_oth = 0; exp_bad = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [3:0] n, input logic [31:0] a);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_n     = n;
        in_addr  = a;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        case (n)
            4'd0: begin exp_rd++;  sb.push_back({2'd0, decode(n, a)}); end
            4'd1: begin exp_wr++;  sb.push_back({2'd0, decode(n, a)}); end
            4'd2: begin exp_if++;  sb.push_back({2'd0, decode(n, a)}); end
            4'd3, 4'd4: begin exp_oth++; sb.push_back({2'd0, decode(n, a)}); end
            4'd8: sb.push_back({2'd1, 36'h0});
            4'd9: sb.push_back({2'd2, 36'h0});
            default: exp_bad++;
        endcase
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || busy) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        total_cnt++;
        if (sb.size() != 0 || busy !== 1'b0)
            $display("FAIL drain pending=%0d busy=%b required pending=0 busy=0", sb.size(), busy);
        else
            pass_cnt++;
    endtask

    // Output monitor, sampled 1 time unit after the falling edge.
    logic [37:0] ev, exp_ev;
    logic        hit;
    logic        prev_valid = 1'b0;
    logic [35:0] prev_instr;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && prev_valid) begin
                total_cnt++;
                if (instruction_o !== prev_instr)
                    $display("FAIL hold_stable instruction_o=%h required %h", instruction_o, prev_instr);
                else
                    pass_cnt++;
            end
            prev_valid = out_valid;
            prev_instr = instruction_o;
            for (int k = 0; k < 3; k++) begin
                hit = (k == 0) ? (out_valid && out_ready) : ((k == 1) ? clear_o : print_o);
                if (hit) begin
                    ev = (k == 0) ? {2'd0, instruction_o} : {2'(k), 36'h0};
                    if (k == 0) stamps.push_back(cyc);
                    total_cnt++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_output event=%h required none", ev);
                    end else begin
                        exp_ev = sb.pop_front();
                        if (ev !== exp_ev)
                            $display("FAIL output_order event=%h required %h", ev, exp_ev);
                        else
                            pass_cnt++;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_n = '0; in_addr = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total_cnt += 6;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required 1", in_ready); else pass_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required 0", out_valid); else pass_cnt++;
        if (instruction_o !== 36'h0) $display("FAIL reset_instr got=%h required 0", instruction_o); else pass_cnt++;
        if ({clear_o, print_o} !== 2'b00) $display("FAIL reset_pulses got=%b required 00", {clear_o, print_o}); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b required 0", busy); else pass_cnt++;
        if ({rd_cnt, wr_cnt, if_cnt, other_cnt, bad_cnt} !== '0)
            $display("FAIL reset_counters got=%h required 0", {rd_cnt, wr_cnt, if_cnt, other_cnt, bad_cnt});
        else pass_cnt++;
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [35:0] want;
        want = {4'h0, 12'h123, 14'h1159, 6'h38};
        out_ready = 1'b1;
        push(4'd0, 32'h1234_5678);
        total_cnt += 6;
        if (out_valid !== 1'b0) $display("FAIL basic_latency_early out_valid=%b required 0", out_valid); else pass_cnt++;
        @(negedge clk);
        if (out_valid !== 1'b1) $display("FAIL basic_out_valid got=%b required 1", out_valid); else pass_cnt++;
        if (instruction_o !== want) $display("FAIL basic_decode got=%h required %h", instruction_o, want); else pass_cnt++;
        @(negedge clk);
        if (out_valid !== 1'b0) $display("FAIL basic_hold1 out_valid=%b required 0", out_valid); else pass_cnt++;
        if (rd_cnt !== CNT_W'(sat(exp_rd))) $display("FAIL basic_rd_cnt got=%0d required %0d", rd_cnt, sat(exp_rd)); else pass_cnt++;
        @(negedge clk);
        if (out_valid !== 1'b0) $display("FAIL basic_hold2 out_valid=%b required 0", out_valid); else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(4'(i % 5), $urandom);
        total_cnt += 3;
        if (in_ready !== 1'b0) $display("FAIL fill_full in_ready=%b required 0", in_ready); else pass_cnt++;
        in_valid = 1'b1; in_n = 4'd0; in_addr = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        if (in_ready !== 1'b0) $display("FAIL fill_still_full in_ready=%b required 0", in_ready); else pass_cnt++;
        if (out_valid !== 1'b1) $display("FAIL fill_stalled out_valid=%b required 1", out_valid); else pass_cnt++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        total_cnt += 4;
        if (rd_cnt !== CNT_W'(sat(exp_rd))) $display("FAIL fill_rd got=%0d required %0d", rd_cnt, sat(exp_rd)); else pass_cnt++;
        if (wr_cnt !== CNT_W'(sat(exp_wr))) $display("FAIL fill_wr got=%0d required %0d", wr_cnt, sat(exp_wr)); else pass_cnt++;
        if (if_cnt !== CNT_W'(sat(exp_if))) $display("FAIL fill_if got=%0d required %0d", if_cnt, sat(exp_if)); else pass_cnt++;
        if (other_cnt !== CNT_W'(sat(exp_oth))) $display("FAIL fill_other got=%0d required %0d", other_cnt, sat(exp_oth)); else pass_cnt++;
    endtask

    task automatic test_specials();
        out_ready = 1'b1;
        push(4'd1, 32'hA000_0040);
        push(4'd8, 32'h0);
        push(4'd2, 32'h0BCD_EF3F);
        push(4'd9, 32'h0);
        wait_drain();
        total_cnt += 2;
        if (wr_cnt !== CNT_W'(sat(exp_wr))) $display("FAIL special_wr got=%0d required %0d", wr_cnt, sat(exp_wr)); else pass_cnt++;
        if (if_cnt !== CNT_W'(sat(exp_if))) $display("FAIL special_if got=%0d required %0d", if_cnt, sat(exp_if)); else pass_cnt++;
    endtask

    task automatic test_bad();
        out_ready = 1'b1;
        push(4'd0, 32'hFFF0_0001);
        push(4'd5, 32'h1111_1111);
        push(4'd15, 32'h2222_2222);
        push(4'd1, 32'h0003_FFC0);
        wait_drain();
        total_cnt += 1;
        if (bad_cnt !== CNT_W'(sat(exp_bad))) $display("FAIL bad_cnt got=%0d required %0d", bad_cnt, sat(exp_bad)); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        out_ready = 1'b0;
        push(4'd0, 32'h1000_0000);
        push(4'd1, 32'h2000_0000);
        push(4'd2, 32'h3000_0000);
        push(4'd3, 32'h4000_0000);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL mid_issue out_valid=%b required 1", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total_cnt += 5;
        if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got=%b required 0", out_valid); else pass_cnt++;
        if (instruction_o !== 36'h0) $display("FAIL mid_rst_instr got=%h required 0", instruction_o); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b required 0", busy); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got=%b required 1", in_ready); else pass_cnt++;
        if (rd_cnt !== '0) $display("FAIL mid_rst_rd_cnt got=%0d required 0", rd_cnt); else pass_cnt++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL mid_stale activity=%b required 0", seen); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b0;
        stamps.delete();
        for (int i = 0; i < DEPTH; i++) push(4'd0, $urandom);
        out_ready = 1'b1;
        wait_drain();
        n = stamps.size();
        total_cnt++;
        if (n != DEPTH) $display("FAIL b2b_count got=%0d required %0d", n, DEPTH); else pass_cnt++;
        for (int i = 1; i < n; i++) begin
            total_cnt++;
            if (stamps[i] - stamps[i-1] != HOLD + 1)
                $display("FAIL b2b_spacing got=%0d required %0d", stamps[i] - stamps[i-1], HOLD + 1);
            else
                pass_cnt++;
        end
        for (int i = 0; i < 10; i++) push(4'd0, $urandom);
        wait_drain();
        total_cnt++;
        if (rd_cnt !== CNT_W'(sat(exp_rd))) $display("FAIL sat_rd got=%h required %h", rd_cnt, sat(exp_rd)); else pass_cnt++;
        push(4'd0, 32'h0000_0001);
        wait_drain();
        total_cnt++;
        if (rd_cnt !== 4'hF) $display("FAIL sat_hold got=%h required F", rd_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_specials();
        test_bad();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
